// File: rtl/sdram_bist.sv
// sdram_bist: self-test initiator for the ram_controller host port.
// Writes address-derived patterns per 64-byte line, reads them back and compares, then repeats inverted.
module sdram_bist #(
  parameter int unsigned NUM_LINES = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic         cpu_clk,
  input  logic         reset_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         timeout,
  output logic [15:0]  error_count,
  output logic [31:0]  fail_addr,
  output logic [3:0]   fail_word,
  output logic         ren,
  output logic         wen,
  output logic [31:0]  address,
  output logic [511:0] data_in,
  output logic [3:0]   mask,
  output logic [7:0]   len,
  input  logic [511:0] data_out,
  input  logic         ready
);

  // state     | meaning
  // S_INIT    | after reset, wait for the controller to report ready
  // S_IDLE    | wait for start
  // S_GAP     | requests low, wait for ready before the next request
  // S_WR_REQ  | wen asserted for one cycle with address/data stable
  // S_WR_WAIT | wen held, wait for ready (operation complete)
  // S_RD_REQ  | ren asserted for one cycle
  // S_RD_WAIT | ren held, wait for ready, capture data_out
  // S_CHECK   | compare captured line against the phase pattern
  // S_DONE    | one-cycle done pulse
  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_GAP, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_CHECK, S_DONE
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
  localparam logic [15:0] LAST_LINE = 16'(NUM_LINES - 1);

  state_t         state, state_next;
  logic [15:0]    line;
  logic           phase;
  logic           next_rd;
  logic [TW-1:0]  tmr;
  logic [511:0]   rd_data;
  logic [511:0]   pattern;
  logic [15:0]    mism;
  logic [4:0]     mism_cnt;
  logic [3:0]     first_idx;
  logic [16:0]    err_sum;
  logic [15:0]    err_next;
  logic           tmr_tc;
  logic           waiting;
  logic           wait_expire;
  logic           last_line;

  function automatic logic [31:0] pat_word(input logic [15:0] wbase, input logic [3:0] idx,
                                           input logic inv);
    logic [15:0] wa;
    wa = wbase + {12'd0, idx};
    return inv ? {~wa, wa} : {wa, ~wa};
  endfunction

  assign address   = BASE_ADDR + {10'd0, line, 6'd0};
  assign last_line = (line == LAST_LINE);
  assign tmr_tc    = (tmr == '0);
  assign waiting   = (state == S_INIT) || (state == S_GAP) ||
                     (state == S_WR_WAIT) || (state == S_RD_WAIT);
  assign wait_expire = waiting && !ready && tmr_tc;

  always_comb begin
    pattern   = '0;
    mism      = '0;
    mism_cnt  = '0;
    first_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      pattern[32*i +: 32] = pat_word(address[17:2], 4'(i), phase);
      mism[i] = (rd_data[32*i +: 32] != pattern[32*i +: 32]);
      mism_cnt = mism_cnt + {4'd0, mism[i]};
    end
    for (int i = 15; i >= 0; i--) begin
      if (mism[i]) first_idx = 4'(i);
    end
    err_sum  = {1'b0, error_count} + {12'd0, mism_cnt};
    err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) state <= S_INIT;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_INIT:    if (ready || tmr_tc) state_next = S_IDLE;
      S_IDLE:    if (start) state_next = S_GAP;
      S_GAP: begin
        if (ready)       state_next = next_rd ? S_RD_REQ : S_WR_REQ;
        else if (tmr_tc) state_next = S_DONE;
      end
      S_WR_REQ:  state_next = S_WR_WAIT;
      S_WR_WAIT: begin
        if (ready)       state_next = S_GAP;
        else if (tmr_tc) state_next = S_DONE;
      end
      S_RD_REQ:  state_next = S_RD_WAIT;
      S_RD_WAIT: begin
        if (ready)       state_next = S_CHECK;
        else if (tmr_tc) state_next = S_DONE;
      end
      S_CHECK:   state_next = (last_line && phase) ? S_DONE : S_GAP;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_INIT;
    endcase
  end

  always_comb begin
    wen     = (state == S_WR_REQ) || (state == S_WR_WAIT);
    ren     = (state == S_RD_REQ) || (state == S_RD_WAIT);
    busy    = (state == S_GAP) || wen || ren || (state == S_CHECK);
    done    = (state == S_DONE);
    data_in = wen ? pattern : '0;
    mask    = 4'b0000;
    len     = 8'd15;
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr         <= TMR_LOAD;
      line        <= '0;
      phase       <= 1'b0;
      next_rd     <= 1'b0;
      rd_data     <= '0;
      error_count <= '0;
      fail_addr   <= '0;
      fail_word   <= '0;
      timeout     <= 1'b0;
      pass        <= 1'b0;
    end else begin
      // Every state change restarts the wait budget for the state being entered.
      if (state_next != state)  tmr <= TMR_LOAD;
      else if (waiting && !tmr_tc) tmr <= tmr - 1'b1;

      if (wait_expire) timeout <= 1'b1;

      if ((state_next == S_DONE) && (state != S_DONE))
        pass <= (state == S_CHECK) && (err_next == 16'd0) && !timeout;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            error_count <= '0;
            fail_addr   <= '0;
            fail_word   <= '0;
            timeout     <= 1'b0;
            pass        <= 1'b0;
            phase       <= 1'b0;
            line        <= '0;
            next_rd     <= 1'b0;
          end
        end
        S_WR_WAIT: begin
          if (ready) begin
            if (last_line) begin
              line    <= '0;
              next_rd <= 1'b1;
            end else begin
              line <= line + 1'b1;
            end
          end
        end
        S_RD_WAIT: if (ready) rd_data <= data_out;
        S_CHECK: begin
          error_count <= err_next;
          if ((error_count == 16'd0) && (mism != 16'd0)) begin
            fail_addr <= address;
            fail_word <= first_idx;
          end
          if (!last_line) begin
            line <= line + 1'b1;
          end else if (!phase) begin
            phase   <= 1'b1;
            line    <= '0;
            next_rd <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
